// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the requesters, the round-robin UART TX arbiter and the UART TX.
// master: the arbiter side; slave: the requesters and the TX driving the arbiter.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_par_en;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            done;
    logic                          tx_busy;
    logic [DATA_WIDTH-1:0]         tx_p_data;
    logic                          tx_data_valid;
    logic                          tx_par_en;
    logic                          arb_busy;
    logic                          timeout_err;

    modport master (
        input  req, req_data, req_par_en, tx_busy,
        output gnt, done, tx_p_data, tx_data_valid, tx_par_en, arb_busy, timeout_err
    );

    modport slave (
        output req, req_data, req_par_en, tx_busy,
        input  gnt, done, tx_p_data, tx_data_valid, tx_par_en, arb_busy, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART TX among NUM_REQ requesters, one frame at a time.
// Optional WAIT_BUSY watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic              CLK,
    input  logic              RST,
    uart_tx_arbiter_if.master bus
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_cfg_check
        $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT at least 1");
    end

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic [NUM_REQ-1:0]      done_q, done_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    par_q, par_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;
    logic                    sel_found;
    logic [IDX_W-1:0]        sel_idx;
    logic [IDX_W-1:0]        cand;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]        cnt_q, cnt_d;
`endif

    // First pending request searching ptr, ptr+1, ... with wrap
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            cand = IDX_W'((32'(ptr_q) + 32'(k)) % NUM_REQ);
            if (!sel_found && bus.req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = '0;
        done_d  = '0;
        valid_d = 1'b0;
        data_d  = data_q;
        par_d   = par_q;
        err_d   = err_q;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d   = (state_q == WAIT_BUSY) ? cnt_q + CNT_W'(1) : '0;
`endif
        case (state_q)
            IDLE: begin
                if (!bus.tx_busy && sel_found) begin
                    state_d        = LAUNCH;
                    idx_d          = sel_idx;
                    gnt_d[sel_idx] = 1'b1;
                    valid_d        = 1'b1;
                    data_d         = bus.req_data[32'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
                    par_d          = bus.req_par_en[sel_idx];
                end
            end
            LAUNCH: state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                // TX never acknowledged the launch: flag it and release the requester
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d         = 1'b1;
                    done_d[idx_q] = 1'b1;
                    ptr_d         = IDX_W'((32'(idx_q) + 32'd1) % NUM_REQ);
                    state_d       = IDLE;
                end
`endif
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    done_d[idx_q] = 1'b1;
                    ptr_d         = IDX_W'((32'(idx_q) + 32'd1) % NUM_REQ);
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            par_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            par_q   <= par_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign bus.gnt           = gnt_q;
    assign bus.done          = done_q;
    assign bus.tx_p_data     = data_q;
    assign bus.tx_data_valid = valid_q;
    assign bus.tx_par_en     = par_q;
    assign bus.arb_busy      = busy_q;
    assign bus.timeout_err   = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter; the TX busy flag is driven by the stimulus.
// Timeout scenario is exercised when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .TIMEOUT(16)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One complete frame from an idle arbiter; returns on the done cycle
    task automatic do_frame(input string tag, input logic [3:0] exp_gnt, input logic [7:0] exp_data,
                            input logic exp_par, input logic [3:0] next_req);
        tick();
        check({tag, "_gnt"},   32'(bus.gnt), 32'(exp_gnt));
        check({tag, "_valid"}, 32'(bus.tx_data_valid), 1);
        check({tag, "_data"},  32'(bus.tx_p_data), 32'(exp_data));
        check({tag, "_par"},   32'(bus.tx_par_en), 32'(exp_par));
        check({tag, "_abusy"}, 32'(bus.arb_busy), 1);
        bus.req = next_req;
        tick();
        check({tag, "_gnt_off"},   32'(bus.gnt), 0);
        check({tag, "_valid_off"}, 32'(bus.tx_data_valid), 0);
        tick();
        bus.tx_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check({tag, "_no_gnt"},  32'(bus.gnt), 0);
            check({tag, "_no_done"}, 32'(bus.done), 0);
            check({tag, "_hold"},    32'(bus.tx_p_data), 32'(exp_data));
            check({tag, "_abusy2"},  32'(bus.arb_busy), 1);
        end
        bus.tx_busy = 1'b0;
        tick();
        check({tag, "_done"},     32'(bus.done), 32'(exp_gnt));
        check({tag, "_idle"},     32'(bus.arb_busy), 0);
        check({tag, "_data_end"}, 32'(bus.tx_p_data), 32'(exp_data));
        check({tag, "_par_end"},  32'(bus.tx_par_en), 32'(exp_par));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},   32'(bus.gnt), 0);
        check({tag, "_done"},  32'(bus.done), 0);
        check({tag, "_data"},  32'(bus.tx_p_data), 0);
        check({tag, "_valid"}, 32'(bus.tx_data_valid), 0);
        check({tag, "_par"},   32'(bus.tx_par_en), 0);
        check({tag, "_abusy"}, 32'(bus.arb_busy), 0);
        check({tag, "_err"},   32'(bus.timeout_err), 0);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst             = 1'b0;
        bus.req         = '0;
        bus.req_data    = {8'h44, 8'hA5, 8'h22, 8'h11};
        bus.req_par_en  = 4'b0101;
        bus.tx_busy     = 1'b0;

        do_reset();
        check_all_zero("reset");

        // Single request; ptr then sits at 3 so an all-ones request grants requester 3
        bus.req = 4'b0100;
        do_frame("single", 4'b0100, 8'hA5, 1'b1, 4'b0000);
        bus.req = 4'b1111;
        do_frame("ptr3", 4'b1000, 8'h44, 1'b0, 4'b0000);

        // Contention from ptr=0
        do_reset();
        bus.req = 4'b1011;
        do_frame("cont0", 4'b0001, 8'h11, 1'b1, 4'b1011);
        do_frame("cont1", 4'b0010, 8'h22, 1'b0, 4'b1011);
        do_frame("cont3", 4'b1000, 8'h44, 1'b0, 4'b1011);
        do_frame("cont0b", 4'b0001, 8'h11, 1'b1, 4'b0000);

        // Fairness: bring ptr to 2, then 0 wins over 1
        bus.req = 4'b0010;
        do_frame("fair_setup", 4'b0010, 8'h22, 1'b0, 4'b0000);
        bus.req = 4'b0011;
        do_frame("fair0", 4'b0001, 8'h11, 1'b1, 4'b0010);
        do_frame("fair1", 4'b0010, 8'h22, 1'b0, 4'b0000);

        // Blocked TX in IDLE
        bus.tx_busy = 1'b1;
        bus.req     = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("blocked_gnt",   32'(bus.gnt), 0);
            check("blocked_valid", 32'(bus.tx_data_valid), 0);
            check("blocked_abusy", 32'(bus.arb_busy), 0);
        end
        bus.tx_busy = 1'b0;
        do_frame("unblocked", 4'b0001, 8'h11, 1'b1, 4'b0000);

        // Reset during WAIT_DONE
        bus.req = 4'b0100;
        tick();
        check("rst_pre_gnt", 32'(bus.gnt), 32'(4'b0100));
        bus.req = 4'b0000;
        tick();
        tick();
        bus.tx_busy = 1'b1;
        tick();
        tick();
        check("rst_pre_abusy", 32'(bus.arb_busy), 1);
        rst = 1'b0;
        tick();
        check_all_zero("rst_mid");
        rst         = 1'b1;
        bus.tx_busy = 1'b0;
        tick();
        check("rst_no_done", 32'(bus.done), 0);
        bus.req = 4'b1111;
        do_frame("rst_next", 4'b0001, 8'h11, 1'b1, 4'b0000);

        // TX never raises busy after a launch
        bus.req = 4'b0100;
        tick();
        check("tmo_gnt", 32'(bus.gnt), 32'(4'b0100));
        bus.req = 4'b0000;
        tick();
`ifdef UART_ARB_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            tick();
            check("tmo_wait_done", 32'(bus.done), 0);
            check("tmo_wait_err",  32'(bus.timeout_err), 0);
        end
        tick();
        check("tmo_done",  32'(bus.done), 32'(4'b0100));
        check("tmo_err",   32'(bus.timeout_err), 1);
        check("tmo_abusy", 32'(bus.arb_busy), 0);
        tick();
        check("tmo_done_off", 32'(bus.done), 0);
        check("tmo_sticky",   32'(bus.timeout_err), 1);
        bus.req = 4'b0001;
        do_frame("tmo_after", 4'b0001, 8'h11, 1'b1, 4'b0000);
        check("tmo_sticky2", 32'(bus.timeout_err), 1);
`else
        for (int i = 0; i < 40; i++) begin
            tick();
            check("hang_done",  32'(bus.done), 0);
            check("hang_abusy", 32'(bus.arb_busy), 1);
        end
        check("hang_err", 32'(bus.timeout_err), 0);
        bus.tx_busy = 1'b1;
        tick();
        bus.tx_busy = 1'b0;
        tick();
        check("hang_done_end", 32'(bus.done), 32'(4'b0100));
        check("hang_err_end",  32'(bus.timeout_err), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
